// File: rtl/boot_mem_pkg.sv
// Shared definitions for the boot memory: state encoding, byte-counter width
// and the default word-address width.
package boot_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int BCNT_W     = 2;

    typedef enum logic [1:0] {
        ST_LEN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/boot_mem_sync_ram.sv
// Single-clock word RAM with a per-bit write mask and a read-first registered
// read port that returns 0 when reads are disabled.
module sync_ram
    import boot_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       wmask,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (wmask[i]) begin
                mem[addr][i] <= wdata[i];
            end
        end
    end

    // Old contents are sampled on the same edge as the write: read-first.
    always_comb begin
        rdata_d = rd_en ? mem[addr] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/boot_mem.sv
// Boot memory: holds the core in reset while filling itself from a byte
// stream (32-bit LE length, then LE words), then serves the core bus.
module boot_mem
    import boot_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_in,
    input  logic [31:0] mem_we,
    output logic [31:0] mem_out,
    output logic        core_rst_n
);

    state_t            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [23:0]       buf_q, buf_d;
    logic              core_rst_n_q, core_rst_n_d;

    logic              run;
    logic              accept;
    logic              load_wr;
    logic [31:0]       ptr_inc;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_wmask;
    logic              unused_addr_bits;

    assign run              = (state_q == ST_RUN);
    assign rx_ready         = rst_n && !run;
    assign accept           = rx_valid && rx_ready;
    assign ptr_inc          = ptr_q + 32'd1;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        buf_d        = buf_q;
        core_rst_n_d = core_rst_n_q;
        load_wr      = 1'b0;
        if (accept) begin
            bcnt_d = bcnt_q + 1'b1;
            case (state_q)
                ST_LEN: begin
                    case (bcnt_q)
                        2'd0:    len_d[7:0]   = rx_data;
                        2'd1:    len_d[15:8]  = rx_data;
                        2'd2:    len_d[23:16] = rx_data;
                        default: begin
                            len_d[31:24] = rx_data;
                            if ({rx_data, len_q[23:0]} == 32'd0) begin
                                state_d      = ST_RUN;
                                core_rst_n_d = 1'b1;
                            end else begin
                                state_d = ST_LOAD;
                                ptr_d   = 32'd0;
                            end
                        end
                    endcase
                end
                ST_LOAD: begin
                    case (bcnt_q)
                        2'd0:    buf_d[7:0]   = rx_data;
                        2'd1:    buf_d[15:8]  = rx_data;
                        2'd2:    buf_d[23:16] = rx_data;
                        default: begin
                            // Final byte goes straight to the RAM with the buffered three.
                            load_wr = 1'b1;
                            ptr_d   = ptr_inc;
                            if (ptr_inc == len_q) begin
                                state_d      = ST_RUN;
                                core_rst_n_d = 1'b1;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LEN;
            bcnt_q       <= '0;
            len_q        <= 32'd0;
            ptr_q        <= 32'd0;
            buf_q        <= 24'd0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            buf_q        <= buf_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Loader owns the RAM until RUN; afterwards the core bus drives it directly.
    assign ram_addr  = run ? mem_addr[ADDR_W+1:2] : ptr_q[ADDR_W-1:0];
    assign ram_wdata = run ? mem_in : {rx_data, buf_q};
    assign ram_wmask = run ? mem_we : {32{load_wr}};

    sync_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (run),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .wmask (ram_wmask),
        .rdata (mem_out)
    );

    assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_boot_mem.sv
// Bench for boot_mem: directed scenarios plus randomized loads and core
// traffic, all compared every cycle against a stream-level reference model.
module tb_boot_mem;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_in = 32'd0;
    logic [31:0] mem_we = 32'd0;
    logic [31:0] mem_out;
    logic        core_rst_n;

    always #5 clk = ~clk;

    boot_mem #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_addr   (mem_addr),
        .mem_in     (mem_in),
        .mem_we     (mem_we),
        .mem_out    (mem_out),
        .core_rst_n (core_rst_n)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts accepted bytes of the current stream and
    // derives length, word index and run status from that count alone.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] known     [DEPTH];
    bit          m_run = 1'b0;
    int          m_nb = 0;
    logic [31:0] m_len = 32'd0;
    logic [31:0] m_word = 32'd0;
    logic [31:0] m_out = 32'd0;
    logic [31:0] m_ok = 32'hFFFF_FFFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_nb  = 0;
            m_len = 32'd0;
            m_out = 32'd0;
            m_ok  = 32'hFFFF_FFFF;
        end else if (m_run) begin
            int idx;
            idx   = int'(mem_addr[AW+1:2]);
            m_out = model_mem[idx];
            m_ok  = known[idx];
            model_mem[idx] = (model_mem[idx] & ~mem_we) | (mem_in & mem_we);
            known[idx]     = known[idx] | mem_we;
        end else begin
            m_out = 32'd0;
            m_ok  = 32'hFFFF_FFFF;
            if (rx_valid) begin
                if (m_nb < 4) begin
                    m_len[8*m_nb +: 8] = rx_data;
                    m_nb++;
                    if (m_nb == 4 && m_len == 32'd0) m_run = 1'b1;
                end else begin
                    int p;
                    int w;
                    p = m_nb - 4;
                    m_word[8*(p%4) +: 8] = rx_data;
                    m_nb++;
                    if (p % 4 == 3) begin
                        w = p / 4;
                        model_mem[w % DEPTH] = m_word;
                        known[w % DEPTH]     = 32'hFFFF_FFFF;
                        if (w + 1 == int'(m_len)) m_run = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_ready", {31'd0, rx_ready}, {31'd0, rst_n && !m_run});
            check("core_rst_n", {31'd0, core_rst_n}, {31'd0, m_run});
            check("mem_out", mem_out & m_ok, m_out & m_ok);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [7:0] b);
        while ($urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        send(b);
    endtask

    task automatic send_word_rand(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_rand(w[8*k +: 8]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic core_op(input logic [31:0] a, input logic [31:0] d, input logic [31:0] we);
        mem_addr = a;
        mem_in   = d;
        mem_we   = we;
        tick();
        mem_we   = 32'd0;
    endtask

    task automatic rand_traffic(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a        = $urandom;
            a[13:2]  = 12'($urandom_range(0, 9));
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            core_op(a, $urandom, ($urandom_range(0, 2) == 0) ? $urandom : 32'd0);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] save0;
        logic [31:0] save1;
        logic [31:0] w;
        int          n;

        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = 32'd0;
            model_mem[i] = 32'd0;
        end

        tick();
        chk_en = 1'b1;
        check("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("reset_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("reset_mem_out", mem_out, 32'd0);
        rst_n = 1'b1;
        tick();
        check("len_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Two-word load with one idle cycle mid-stream.
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        send(8'h78); send(8'h56);
        tick();
        send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check("load_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check("load_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("model_word0", model_mem[0], 32'h1234_5678);
        core_op(32'h0, 32'h0, 32'h0);
        check("read_w0", mem_out, 32'h1234_5678);
        core_op(32'h4, 32'h0, 32'h0);
        check("read_w1", mem_out, 32'hDEAD_BEEF);

        // Zero-length stream, then a stray byte that must stay unconsumed.
        do_reset();
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        check("zero_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        tick();
        check("zero_rx_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;

        // Bit-mask write with same-cycle read of the old value.
        core_op(32'h4, 32'hFFFF_FFFF, 32'h0000_FF00);
        check("mask_read_first", mem_out, 32'hDEAD_BEEF);
        core_op(32'h4, 32'h0, 32'h0);
        check("mask_after", mem_out, 32'hDEAD_FFEF);
        check("model_mask", model_mem[1], 32'hDEAD_FFEF);

        // Address aliasing above the word index and in the byte-offset bits.
        core_op(32'h4000, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        core_op(32'h3, 32'h0, 32'h0);
        check("alias_low_bits", mem_out, 32'hA5A5_A5A5);
        core_op(32'h0, 32'h0, 32'h0);
        check("alias_word0", mem_out, 32'hA5A5_A5A5);

        // Reset from RUN clears outputs asynchronously.
        rst_n = 1'b0;
        #1;
        check("async_mem_out", mem_out, 32'd0);
        check("async_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Reset part-way through a three-word load, then a fresh one-word load.
        send(8'h03); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11); send(8'h22);
        rst_n = 1'b0;
        #1;
        check("midload_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("midload_mem_out", mem_out, 32'd0);
        tick();
        rst_n = 1'b1;
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        check("reload_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        core_op(32'h0, 32'h0, 32'h0);
        check("reload_w0", mem_out, 32'hDDCC_BBAA);
        core_op(32'h4, 32'h0, 32'h0);
        check("reload_w1_kept", mem_out, 32'hDEAD_FFEF);

        // Randomized short loads with bubbles, followed by core traffic.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            n = $urandom_range(1, 8);
            send_word_rand(n);
            for (int i = 0; i < n; i++) send_word_rand($urandom);
            check("rand_core_rst_n", {31'd0, core_rst_n}, 32'd1);
            rand_traffic(150);
        end

        // Over-long load wraps the pointer: the last two words land in 0 and 1.
        do_reset();
        send_word_rand(DEPTH + 2);
        save0 = 32'd0;
        save1 = 32'd0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            w = $urandom;
            if (i == DEPTH)     save0 = w;
            if (i == DEPTH + 1) save1 = w;
            send_word_rand(w);
        end
        check("wrap_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check("model_wrap", model_mem[0], save0);
        core_op(32'h0, 32'h0, 32'h0);
        check("wrap_w0", mem_out, save0);
        core_op(32'h4, 32'h0, 32'h0);
        check("wrap_w1", mem_out, save1);
        rand_traffic(100);

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
